// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MEM-stage load/store controller.
// Latency: n/a (types, constants and a pure request-check function).
// Backpressure: n/a.
package mips_mem_pkg;

    localparam int DEF_MEM_WORDS = 226;
    localparam int DEF_ADDR_W    = 8;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_RMW_RD = 3'd2,
        ST_SETUP  = 3'd3,
        ST_STROBE = 3'd4,
        ST_RESP   = 3'd5
    } state_e;

    // A request is rejected for an illegal size, a misaligned half/word,
    // any address bit above the 1 KiB window, or a word index past the RAM.
    function automatic logic req_is_err(input logic [1:0]  size,
                                        input logic [31:0] addr,
                                        input int          mem_words);
        logic e;
        e = 1'b0;
        if (size == SZ_ILL)                            e = 1'b1;
        if (size == SZ_HALF && addr[0])                e = 1'b1;
        if (size == SZ_WORD && addr[1:0] != 2'b00)     e = 1'b1;
        if (addr[31:10] != 22'd0)                      e = 1'b1;
        if ({24'd0, addr[9:2]} >= 32'(mem_words))      e = 1'b1;
        return e;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Pipeline request/response and RAM-side signals of the load/store controller.
// Latency: n/a (wiring only).
// Backpressure: req_ready gates requests; responses are unconditional pulses.
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_err;
    logic [31:0]       resp_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic              ram_oe;
    logic              ram_ws;
    logic [31:0]       ram_rdata;

    // Controller side
    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, ram_rdata,
        output req_ready, resp_valid, resp_err, resp_rdata,
               ram_addr, ram_wdata, ram_oe, ram_ws
    );

    // Pipeline + RAM side
    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, ram_rdata,
        input  req_ready, resp_valid, resp_err, resp_rdata,
               ram_addr, ram_wdata, ram_oe, ram_ws
    );
endinterface

// File: rtl/mem_lane_fmt.sv
// Byte-lane formatter: merges store bytes into a word and extracts/extends loads.
// Latency: combinational.
// Backpressure: none.
module mem_lane_fmt
    import mips_mem_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_signed,
    input  logic [31:0] old_word,
    input  logic [31:0] store_data,
    output logic [31:0] merged_word,
    output logic [31:0] load_value
);
    logic [31:0] shifted;

    // Little-endian lane select: lane k lives in bits [8k+7:8k]
    always_comb begin
        merged_word = old_word;
        load_value  = 32'd0;
        shifted     = old_word >> {offset, 3'b000};
        case (size)
            SZ_BYTE: begin
                for (int k = 0; k < 4; k++) begin
                    if (offset == 2'(k)) merged_word[8*k +: 8] = store_data[7:0];
                end
                load_value = {{24{is_signed & shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                if (offset[1]) merged_word[31:16] = store_data[15:0];
                else           merged_word[15:0]  = store_data[15:0];
                load_value = {{16{is_signed & shifted[15]}}, shifted[15:0]};
            end
            default: begin
                merged_word = store_data;
                load_value  = old_word;
            end
        endcase
    end
endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller driving a word RAM (byte/half via read-modify-write).
// Latency: error 1, load 2, word store 3, sub-word store 4 edges to resp_valid.
// Backpressure: one request in flight; req_ready only in IDLE; resp_valid is never stalled.
module mem_access_ctrl
    import mips_mem_pkg::*;
#(
    parameter int MEM_WORDS = DEF_MEM_WORDS,
    parameter int ADDR_W    = DEF_ADDR_W
)(
    input  logic               clk,
    input  logic               rst_n,
    mem_access_ctrl_if.slave   bus
);
    state_e              state_q, state_d;
    logic                ram_oe_q, ram_oe_d;
    logic                ram_ws_q, ram_ws_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [31:0]         ram_wdata_q, ram_wdata_d;
    logic                resp_valid_q, resp_valid_d;
    logic                resp_err_q, resp_err_d;
    logic [31:0]         resp_rdata_q, resp_rdata_d;
    logic [1:0]          size_q, size_d;
    logic                signed_q, signed_d;
    logic [1:0]          off_q, off_d;
    logic [31:0]         wdata_q, wdata_d;

    logic [31:0]         merged_word;
    logic [31:0]         load_value;

    mem_lane_fmt u_lane_fmt (
        .offset      (off_q),
        .size        (size_q),
        .is_signed   (signed_q),
        .old_word    (bus.ram_rdata),
        .store_data  (wdata_q),
        .merged_word (merged_word),
        .load_value  (load_value)
    );

    // Next-state and next-output logic; every output is a flop so ram_ws cannot glitch
    always_comb begin
        state_d      = state_q;
        ram_oe_d     = ram_oe_q;
        ram_ws_d     = ram_ws_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        resp_valid_d = 1'b0;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;
        size_d       = size_q;
        signed_d     = signed_q;
        off_d        = off_q;
        wdata_d      = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    size_d     = bus.req_size;
                    signed_d   = bus.req_signed;
                    off_d      = bus.req_addr[1:0];
                    wdata_d    = bus.req_wdata;
                    ram_addr_d = bus.req_addr[ADDR_W+1:2];
                    if (req_is_err(bus.req_size, bus.req_addr, MEM_WORDS)) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'd0;
                    end else if (!bus.req_we) begin
                        state_d  = ST_READ;
                        ram_oe_d = 1'b1;
                    end else if (bus.req_size == SZ_WORD) begin
                        state_d     = ST_SETUP;
                        ram_wdata_d = bus.req_wdata;
                    end else begin
                        state_d  = ST_RMW_RD;
                        ram_oe_d = 1'b1;
                    end
                end
            end
            ST_READ: begin
                ram_oe_d     = 1'b0;
                resp_rdata_d = load_value;
                resp_err_d   = 1'b0;
                resp_valid_d = 1'b1;
                state_d      = ST_RESP;
            end
            ST_RMW_RD: begin
                ram_oe_d    = 1'b0;
                ram_wdata_d = merged_word;
                state_d     = ST_SETUP;
            end
            ST_SETUP: begin
                ram_ws_d = 1'b1;
                state_d  = ST_STROBE;
            end
            ST_STROBE: begin
                ram_ws_d     = 1'b0;
                resp_err_d   = 1'b0;
                resp_rdata_d = 32'd0;
                resp_valid_d = 1'b1;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                resp_err_d   = 1'b0;
                resp_rdata_d = 32'd0;
                state_d      = ST_IDLE;
            end
            default: begin
                ram_oe_d     = 1'b0;
                ram_ws_d     = 1'b0;
                resp_err_d   = 1'b0;
                resp_rdata_d = 32'd0;
                state_d      = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops ram_ws immediately without a second edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ram_oe_q     <= 1'b0;
            ram_ws_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
            size_q       <= 2'd0;
            signed_q     <= 1'b0;
            off_q        <= 2'd0;
            wdata_q      <= 32'd0;
        end else begin
            state_q      <= state_d;
            ram_oe_q     <= ram_oe_d;
            ram_ws_q     <= ram_ws_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            off_q        <= off_d;
            wdata_q      <= wdata_d;
        end
    end

    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.ram_oe     = ram_oe_q;
    assign bus.ram_ws     = ram_ws_q;
    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_wdata  = ram_wdata_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: byte-array memory model, directed cases, then random traffic.
// Latency: n/a.
// Backpressure: bench waits on req_ready before each request.
module tb_mem_access_ctrl;
    logic clk;
    logic rst_n;

    mem_access_ctrl_if #(.ADDR_W(8)) bus ();

    mem_access_ctrl #(.MEM_WORDS(226), .ADDR_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word RAM behaving like the real part: writes on the rising edge of ram_ws
    logic [31:0] ram_words [0:255];
    int          ws_cnt;
    int          oe_cnt;
    assign bus.ram_rdata = ram_words[bus.ram_addr];

    always @(posedge bus.ram_ws) begin
        ram_words[bus.ram_addr] = bus.ram_wdata;
        ws_cnt++;
    end

    always @(negedge clk) begin
        if (bus.ram_oe) oe_cnt++;
    end

    // Reference memory kept as bytes, byte address = index
    logic [7:0] mem_b [0:1023];

    int n_chk;
    int n_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic model_err(input logic [1:0] sz, input logic [31:0] a);
        int nbytes;
        if (sz == 2'b11) return 1'b1;
        nbytes = 1 << sz;
        if (a % nbytes != 0) return 1'b1;
        if (a >= 32'd1024) return 1'b1;
        if (a / 4 >= 226) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sg, input logic [31:0] a);
        int nbytes;
        logic [31:0] v;
        nbytes = 1 << sz;
        v = 32'd0;
        for (int i = 0; i < nbytes; i++) v = v | (32'(mem_b[a + i]) << (8 * i));
        if (sg && v[8*nbytes-1]) begin
            for (int i = 8 * nbytes; i < 32; i++) v[i] = 1'b1;
        end
        return v;
    endfunction

    task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        int nbytes;
        nbytes = 1 << sz;
        for (int i = 0; i < nbytes; i++) mem_b[a + i] = wd[8*i +: 8];
    endtask

    // Issue one request, follow it to its response and check everything about it
    task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd, input logic keep);
        logic        exp_err;
        logic [31:0] exp_v;
        int          exp_lat, exp_oe, exp_ws;
        int          ws0, oe0, lat;
        bit          got;
        exp_err = model_err(sz, a);
        exp_lat = exp_err ? 1 : (!we ? 2 : (sz == 2'b10 ? 3 : 4));
        exp_oe  = exp_err ? 0 : ((!we || sz != 2'b10) ? 1 : 0);
        exp_ws  = (!exp_err && we) ? 1 : 0;
        bus.req_we     = we;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.req_valid  = 1'b1;
        ws0 = ws_cnt;
        oe0 = oe_cnt;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus.req_ready) got = 1;
        end
        if (!got) begin
            chk("accept_timeout", 32'd0, 32'd1);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (!keep) bus.req_valid = 1'b0;
        chk("busy_ready", 32'(bus.req_ready), 32'd0);
        lat = 1;
        while (!bus.resp_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!bus.resp_valid) begin
            chk("resp_timeout", 32'd0, 32'd1);
            return;
        end
        exp_v = (!exp_err && !we) ? model_load(sz, sg, a) : 32'd0;
        if (!exp_err && we) model_store(sz, a, wd);
        chk("latency",   32'(lat), 32'(exp_lat));
        chk("resp_err",  32'(bus.resp_err), 32'(exp_err));
        chk("resp_rdata", bus.resp_rdata, exp_v);
        chk("ram_addr",  32'(bus.ram_addr), {24'd0, a[9:2]});
        chk("ws_edges",  32'(ws_cnt - ws0), 32'(exp_ws));
        chk("oe_cycles", 32'(oe_cnt - oe0), 32'(exp_oe));
        @(posedge clk);
        #1;
        chk("resp_pulse", 32'(bus.resp_valid), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
        chk({tag, "_oe"},    32'(bus.ram_oe), 32'd0);
        chk({tag, "_ws"},    32'(bus.ram_ws), 32'd0);
        chk({tag, "_addr"},  32'(bus.ram_addr), 32'd0);
        chk({tag, "_wdata"}, bus.ram_wdata, 32'd0);
        chk({tag, "_rv"},    32'(bus.resp_valid), 32'd0);
        chk({tag, "_rerr"},  32'(bus.resp_err), 32'd0);
        chk({tag, "_rdata"}, bus.resp_rdata, 32'd0);
    endtask

    initial begin
        int ws0, oe0;
        logic [31:0] a, wd;
        logic [1:0]  sz;
        int r;
        n_chk = 0;
        n_err = 0;
        ws_cnt = 0;
        oe_cnt = 0;
        bus.req_valid = 1'b0;
        bus.req_we = 1'b0;
        bus.req_size = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr = 32'd0;
        bus.req_wdata = 32'd0;
        for (int w = 0; w < 256; w++) begin
            ram_words[w] = $urandom;
            for (int b = 0; b < 4; b++) mem_b[4*w + b] = ram_words[w][8*b +: 8];
        end
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Word store/load round trip
        do_req(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0);
        do_req(0, 2'b10, 0, 32'h10, 32'h0, 0);
        // Byte RMW into a known word
        do_req(1, 2'b10, 0, 32'h10, 32'h11223344, 0);
        do_req(1, 2'b00, 0, 32'h13, 32'h000000AA, 0);
        chk("rmw_byte_word", ram_words[4], 32'hAA223344);
        do_req(0, 2'b00, 1, 32'h13, 32'h0, 0);
        do_req(0, 2'b00, 0, 32'h13, 32'h0, 0);
        // Half RMW over zero
        do_req(1, 2'b10, 0, 32'h20, 32'h0, 0);
        do_req(1, 2'b01, 0, 32'h22, 32'h00008001, 0);
        chk("rmw_half_word", ram_words[8], 32'h80010000);
        do_req(0, 2'b01, 1, 32'h22, 32'h0, 0);
        do_req(0, 2'b01, 0, 32'h22, 32'h0, 0);
        // Error cases
        do_req(0, 2'b10, 0, 32'h11, 32'h0, 0);
        do_req(0, 2'b01, 0, 32'h21, 32'h0, 0);
        do_req(1, 2'b11, 0, 32'h30, 32'h12345678, 0);
        do_req(0, 2'b10, 0, 32'h388, 32'h0, 0);
        do_req(1, 2'b10, 0, 32'h384, 32'hCAFEF00D, 0);
        do_req(1, 2'b10, 0, 32'h400, 32'hCAFEF00D, 0);

        // Reset during STROBE: exactly one write must land
        bus.req_we = 1'b1; bus.req_size = 2'b10; bus.req_signed = 1'b0;
        bus.req_addr = 32'h40; bus.req_wdata = 32'h55555555; bus.req_valid = 1'b1;
        ws0 = ws_cnt;
        @(negedge clk);
        chk("strobe_rst_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        chk("strobe_ws_high", 32'(bus.ram_ws), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("strobe_rst");
        model_store(2'b10, 32'h40, 32'h55555555);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("strobe_rst_writes", 32'(ws_cnt - ws0), 32'd1);
        chk("strobe_rst_word", ram_words[16], 32'h55555555);

        // Reset during RMW_RD: no write at all
        bus.req_we = 1'b1; bus.req_size = 2'b00; bus.req_signed = 1'b0;
        bus.req_addr = 32'h45; bus.req_wdata = 32'h77; bus.req_valid = 1'b1;
        ws0 = ws_cnt;
        @(negedge clk);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("rmw_rst_oe_high", 32'(bus.ram_oe), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rmw_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1 chk("rmw_rst_writes", 32'(ws_cnt - ws0), 32'd0);
        do_req(0, 2'b10, 0, 32'h44, 32'h0, 0);
        do_req(0, 2'b10, 0, 32'h40, 32'h0, 0);

        // Back-to-back stream with req_valid held high
        for (int i = 0; i < 12; i++) begin
            do_req(1'(i % 2), 2'(i % 3), 1'(i % 2), 32'h80 + 32'(4 * (i / 2)), $urandom, 1);
        end
        bus.req_valid = 1'b0;

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 7);
            sz = (r < 3) ? 2'b00 : (r < 5) ? 2'b01 : (r < 7) ? 2'b10 : 2'b11;
            r = $urandom_range(0, 15);
            if (r == 0)      a = $urandom;
            else if (r == 1) a = 32'h388 + 32'($urandom_range(0, 200));
            else             a = 32'($urandom_range(0, 903));
            if (sz != 2'b00 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            wd = $urandom;
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, wd,
                   1'($urandom_range(0, 1)));
        end
        bus.req_valid = 1'b0;
        repeat (2) @(posedge clk);

        // Final memory image against the byte model
        oe0 = 0;
        for (int w = 0; w < 226; w++) begin
            chk("final_word", ram_words[w],
                {mem_b[4*w+3], mem_b[4*w+2], mem_b[4*w+1], mem_b[4*w]});
            oe0++;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
